// File: rtl/tlp_tx_sched.sv
// Purpose : transmit scheduler; queues receiver actions in an in-order FIFO and
//           round-robins them with FPGA->CPU DMA burst requests toward the sender.
// Latency : push to txValid_out 2 cycles when idle; 3 clocks minimum per item.
// Backpressure: the action producer is never stalled (overflow drops and sets a
//           sticky flag); txValid_out holds with stable payload until txReady_in.
// Ports   : pcieClk_in/pcieRst_in clock and async high reset; actData_in/actValid_in
//           action push; dmaReq_in/dmaLen_in/dmaAck_out DMA request and grant;
//           txData_out/txIsDma_out/txLen_out/txValid_out/txReady_in issue channel;
//           txDone_in sender completion; fifoLevel_out occupancy; ovfError_out sticky drop.
module tlp_tx_sched #(
  parameter int ACT_W = 64,
  parameter int DEPTH = 8
) (
  input  logic                       pcieClk_in,
  input  logic                       pcieRst_in,
  input  logic [ACT_W-1:0]           actData_in,
  input  logic                       actValid_in,
  input  logic                       dmaReq_in,
  input  logic [4:0]                 dmaLen_in,
  output logic                       dmaAck_out,
  output logic [ACT_W-1:0]           txData_out,
  output logic                       txIsDma_out,
  output logic [4:0]                 txLen_out,
  output logic                       txValid_out,
  input  logic                       txReady_in,
  input  logic                       txDone_in,
  output logic [$clog2(DEPTH):0]     fifoLevel_out,
  output logic                       ovfError_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ACT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              ovf;
  logic              last_grant_dma;

  logic act_pend;
  logic grant;
  logic grant_dma;
  logic handshake;
  logic pop;
  logic push;

  assign act_pend  = (level != '0);
  assign grant     = (state == S_IDLE) && (act_pend || dmaReq_in);
  // DMA wins when it is the only source, or when both contend and actions went last.
  assign grant_dma = dmaReq_in && (!act_pend || !last_grant_dma);
  assign handshake = (state == S_ISSUE) && txReady_in;
  assign pop       = handshake && !txIsDma_out;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push      = actValid_in && ((level != FULL_LVL) || pop);

  assign fifoLevel_out = level;
  assign ovfError_out  = ovf;

  // Storage needs no reset: level and pointers define which entries are valid.
  always_ff @(posedge pcieClk_in) begin
    if (push) mem[wr_ptr] <= actData_in;
  end

  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (actValid_in && !push) ovf <= 1'b1;
    end
  end

  // Issue payload is captured at grant time so it stays stable through S_ISSUE
  // even though the FIFO head or dmaLen_in may move underneath it.
  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      txData_out     <= '0;
      txIsDma_out    <= 1'b0;
      txLen_out      <= '0;
      last_grant_dma <= 1'b1;
    end else if (grant) begin
      last_grant_dma <= grant_dma;
      txIsDma_out    <= grant_dma;
      txData_out     <= grant_dma ? '0 : mem[rd_ptr];
      txLen_out      <= grant_dma ? dmaLen_in : 5'd0;
    end
  end

  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant)      state_nxt = S_ISSUE;
      S_ISSUE: if (txReady_in) state_nxt = S_BUSY;
      S_BUSY:  if (txDone_in)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    txValid_out = 1'b0;
    dmaAck_out  = 1'b0;
    if (state == S_ISSUE) begin
      txValid_out = 1'b1;
      dmaAck_out  = txReady_in && txIsDma_out;
    end
  end

endmodule

// File: tb/tb_tlp_tx_sched.sv
// Purpose : self-checking bench for tlp_tx_sched with an issue-order scoreboard.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: txReady_in scripted per scenario; txDone_in pulsed after handshakes.
module tb_tlp_tx_sched;

  typedef struct {
    logic [63:0] data;
    logic        is_dma;
    logic [4:0]  len;
  } item_t;

  logic        clk;
  logic        rst;
  logic [63:0] act_data;
  logic        act_valid;
  logic        dma_req;
  logic [4:0]  dma_len;
  logic        dma_ack;
  logic [63:0] tx_data;
  logic        tx_is_dma;
  logic [4:0]  tx_len;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;
  logic [3:0]  level;
  logic        ovf;

  int    checks   = 0;
  int    failures = 0;
  item_t expq[$];
  bit    auto_done = 0;
  bit    done_due  = 0;
  int    dma_acks  = 0;
  bit    stalled   = 0;
  item_t snap;

  tlp_tx_sched dut (
    .pcieClk_in   (clk),
    .pcieRst_in   (rst),
    .actData_in   (act_data),
    .actValid_in  (act_valid),
    .dmaReq_in    (dma_req),
    .dmaLen_in    (dma_len),
    .dmaAck_out   (dma_ack),
    .txData_out   (tx_data),
    .txIsDma_out  (tx_is_dma),
    .txLen_out    (tx_len),
    .txValid_out  (tx_valid),
    .txReady_in   (tx_ready),
    .txDone_in    (tx_done),
    .fifoLevel_out(level),
    .ovfError_out (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every issue handshake must match the next expected item.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== snap.data || tx_is_dma !== snap.is_dma || tx_len !== snap.len) begin
          failures++;
          $display("FAIL stall_hold: got v=%0b d=%0h dma=%0b len=%0d want v=1 d=%0h dma=%0b len=%0d",
                   tx_valid, tx_data, tx_is_dma, tx_len, snap.data, snap.is_dma, snap.len);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        item_t e;
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue: got d=%0h dma=%0b len=%0d want none", tx_data, tx_is_dma, tx_len);
        end else begin
          e = expq.pop_front();
          if (tx_data !== e.data || tx_is_dma !== e.is_dma || tx_len !== e.len) begin
            failures++;
            $display("FAIL issue_item: got d=%0h dma=%0b len=%0d want d=%0h dma=%0b len=%0d",
                     tx_data, tx_is_dma, tx_len, e.data, e.is_dma, e.len);
          end
        end
        done_due = 1;
        if (dma_ack === 1'b1) dma_acks++;
      end
      checks++;
      if (dma_ack !== (tx_valid === 1'b1 && tx_ready === 1'b1 && tx_is_dma === 1'b1)) begin
        failures++;
        $display("FAIL dma_ack_pulse: got %0b want %0b", dma_ack, tx_valid && tx_ready && tx_is_dma);
      end
      stalled = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      snap.data = tx_data; snap.is_dma = tx_is_dma; snap.len = tx_len;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tx_done = auto_done && done_due;
    if (tx_done) done_due = 0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1; act_valid = 0; act_data = '0; dma_req = 0; dma_len = '0; tx_ready = 0; tx_done = 0;
    auto_done = 0;
    tick(); tick();
    rst = 0;
    expq.delete();
    done_due = 0;
    dma_acks = 0;
  endtask

  // Advances until the scoreboard drains, releasing dmaReq once it is acknowledged.
  task automatic run_until_empty(input int budget);
    for (int i = 0; i < budget && expq.size() != 0; i++) begin
      tick();
      if (dma_acks != 0) dma_req = 0;
    end
    repeat (4) begin
      tick();
      if (dma_acks != 0) dma_req = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; act_valid = 1; act_data = 64'hDEAD; dma_req = 1; dma_len = 5'd9; tx_ready = 1; tx_done = 0;
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b0)  begin failures++; $display("FAIL rst_valid: got %0b want 0", tx_valid); end
    checks++; if (dma_ack !== 1'b0)   begin failures++; $display("FAIL rst_ack: got %0b want 0", dma_ack); end
    checks++; if (tx_data !== 64'h0)  begin failures++; $display("FAIL rst_data: got %0h want 0", tx_data); end
    checks++; if (tx_is_dma !== 1'b0) begin failures++; $display("FAIL rst_isdma: got %0b want 0", tx_is_dma); end
    checks++; if (tx_len !== 5'd0)    begin failures++; $display("FAIL rst_len: got %0d want 0", tx_len); end
    checks++; if (level !== 4'd0)     begin failures++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL rst_ovf: got %0b want 0", ovf); end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    tick(); act_valid = 1; act_data = 64'h1234; tx_ready = 1;
    expq.push_back('{64'h1234, 1'b0, 5'd0});
    tick(); act_valid = 0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL lat_c1_valid: got %0b want 0", tx_valid); end
    checks++; if (level !== 4'd1)    begin failures++; $display("FAIL lat_c1_level: got %0d want 1", level); end
    tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1)     begin failures++; $display("FAIL lat_c2_valid: got %0b want 1", tx_valid); end
    checks++; if (tx_data !== 64'h1234)  begin failures++; $display("FAIL lat_c2_data: got %0h want 1234", tx_data); end
    tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL lat_busy_valid: got %0b want 0", tx_valid); end
    checks++; if (level !== 4'd0)    begin failures++; $display("FAIL lat_busy_level: got %0d want 0", level); end
    tick(); tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL lat_busy_hold: got %0b want 0", tx_valid); end
    tick(); tx_done = 1;
    tick(); act_valid = 1; act_data = 64'h55; done_due = 0;
    expq.push_back('{64'h55, 1'b0, 5'd0});
    tick(); act_valid = 0;
    tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 64'h55) begin
      failures++; $display("FAIL lat_after_done: got v=%0b d=%0h want v=1 d=55", tx_valid, tx_data);
    end
    auto_done = 1;
    run_until_empty(40);
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL lat_drain: got %0d left want 0", expq.size()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    auto_done = 1;
    tick(); act_valid = 1; act_data = 64'hA0;
    expq.push_back('{64'hA0, 1'b0, 5'd0});
    tick(); act_data = 64'hA1;
    tick(); act_valid = 0; dma_req = 1; dma_len = 5'd7; tx_ready = 1;
    expq.push_back('{64'h0, 1'b1, 5'd7});
    expq.push_back('{64'hA1, 1'b0, 5'd0});
    run_until_empty(60);
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL rr_drain: got %0d left want 0", expq.size()); end
    checks++; if (dma_acks != 1)    begin failures++; $display("FAIL rr_ack_count: got %0d want 1", dma_acks); end
    checks++; if (level !== 4'd0)   begin failures++; $display("FAIL rr_level: got %0d want 0", level); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      tick(); act_valid = 1; act_data = 64'(i);
      if (i <= 8) expq.push_back('{64'(i), 1'b0, 5'd0});
    end
    tick(); act_valid = 0;
    @(negedge clk);
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL ovf_level: got %0d want 8", level); end
    checks++; if (ovf !== 1'b1)   begin failures++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
    tick(); tx_ready = 1; auto_done = 1;
    run_until_empty(100);
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL ovf_drain: got %0d left want 0", expq.size()); end
    checks++; if (level !== 4'd0)   begin failures++; $display("FAIL ovf_level_end: got %0d want 0", level); end
    checks++; if (ovf !== 1'b1)     begin failures++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); dma_req = 1; dma_len = 5'd19;
    expq.push_back('{64'h0, 1'b1, 5'd19});
    tick(); dma_len = 5'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 64'h0 || tx_is_dma !== 1'b1 || tx_len !== 5'd19 || dma_ack !== 1'b0) begin
        failures++;
        $display("FAIL stall_cycle%0d: got v=%0b d=%0h dma=%0b len=%0d ack=%0b want v=1 d=0 dma=1 len=19 ack=0",
                 k, tx_valid, tx_data, tx_is_dma, tx_len, dma_ack);
      end
      tick();
    end
    tx_ready = 1; auto_done = 1;
    run_until_empty(40);
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d left want 0", expq.size()); end
    checks++; if (dma_acks != 1)    begin failures++; $display("FAIL stall_ack_count: got %0d want 1", dma_acks); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(); act_valid = 1; act_data = 64'(16 + i);
      expq.push_back('{64'(16 + i), 1'b0, 5'd0});
    end
    tick(); act_data = 64'd24; tx_ready = 1; auto_done = 1;
    expq.push_back('{64'd24, 1'b0, 5'd0});
    @(negedge clk);
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_pre_level: got %0d want 8", level); end
    tick(); act_valid = 0;
    @(negedge clk);
    checks++; if (level !== 4'd8) begin failures++; $display("FAIL full_pushpop_level: got %0d want 8", level); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL full_pushpop_ovf: got %0b want 0", ovf); end
    run_until_empty(100);
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL full_drain: got %0d left want 0", expq.size()); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); act_valid = 1; act_data = 64'(8'hC0 + i);
      if (i == 0) expq.push_back('{64'hC0, 1'b0, 5'd0});
    end
    tick(); act_valid = 0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || level !== 4'd3 || tx_data !== 64'hC0) begin
      failures++; $display("FAIL rb_busy: got v=%0b lvl=%0d d=%0h want v=0 lvl=3 d=c0", tx_valid, level, tx_data);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || dma_ack !== 1'b0 || tx_data !== 64'h0 || tx_is_dma !== 1'b0 ||
        tx_len !== 5'd0 || level !== 4'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL rb_async: got v=%0b ack=%0b d=%0h dma=%0b len=%0d lvl=%0d ovf=%0b want all 0",
               tx_valid, dma_ack, tx_data, tx_is_dma, tx_len, level, ovf);
    end
    tick(); tick();
    rst = 0; done_due = 0;
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL rb_pending: got %0d want 0", expq.size()); end
    tick(); act_valid = 1; act_data = 64'h77; auto_done = 1;
    expq.push_back('{64'h77, 1'b0, 5'd0});
    tick(); act_valid = 0;
    tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 64'h77) begin
      failures++; $display("FAIL rb_resume: got v=%0b d=%0h want v=1 d=77", tx_valid, tx_data);
    end
    run_until_empty(40);
    checks++; if (expq.size() != 0) begin failures++; $display("FAIL rb_drain: got %0d left want 0", expq.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_stall();
    test_full_push_pop();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
